// File: rtl/mem_if.sv
// Cache-port bundle between a CPU initiator and a memory responder: level read/write
// requests held until a one-cycle resp, byte-lane write masks, 32-bit data.
interface mem_if;
    logic        read;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] rdata;

    modport master (output read, write, wmask, address, wdata, input resp, rdata);
    modport slave  (input read, write, wmask, address, wdata, output resp, rdata);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory behind the cache port, answering every request after a fixed
// LATENCY with a one-cycle resp; writes honour byte-lane masks, reads return the old word.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic  clk,
    input  logic  reset_n,
    mem_if.slave  bus
);
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wmask_q, wmask_d;
    logic                  wr_q, wr_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0] mem [DEPTH];

    logic                  perform;
    logic [DEPTH_LOG2-1:0] op_idx;
    logic [31:0]           op_wdata;
    logic [3:0]            op_wmask;
    logic                  op_wr;

    // In IDLE the op (only possible with LATENCY=1) comes straight off the bus.
    always_comb begin
        if (state_q == IDLE) begin
            op_idx   = bus.address[DEPTH_LOG2+1:2];
            op_wdata = bus.wdata;
            op_wmask = bus.wmask;
            op_wr    = bus.write;
        end else begin
            op_idx   = idx_q;
            op_wdata = wdata_q;
            op_wmask = wmask_q;
            op_wr    = wr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        perform = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.read || bus.write) begin
                    idx_d   = bus.address[DEPTH_LOG2+1:2];
                    wdata_d = bus.wdata;
                    wmask_d = bus.wmask;
                    wr_d    = bus.write;
                    if (LATENCY == 1) begin
                        perform = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CW'(LATENCY - 2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    perform = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (perform) rdata_d = mem[op_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is deliberately unreset; reset_n gate stops a held LATENCY=1 write landing in reset.
    always_ff @(posedge clk) begin
        if (perform && op_wr && reset_n) begin
            for (int i = 0; i < 4; i++) begin
                if (op_wmask[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
            end
        end
    end

    assign bus.resp  = (state_q == DONE);
    assign bus.rdata = rdata_q;

    logic unused_addr;
    assign unused_addr = ^{bus.address[31:DEPTH_LOG2+2], bus.address[1:0]};
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: drivers push expected completions (rdata and cycle), per-DUT monitors
// pop and compare on every resp. One responder at LATENCY=2, one at LATENCY=1.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_if m0 ();
    mem_if m1 ();

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) d0 (.clk(clk), .reset_n(rst_n), .bus(m0));
    mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) d1 (.clk(clk), .reset_n(rst_n), .bus(m1));

    typedef struct {
        logic [31:0] rd;
        logic        chk;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0 && cyc > q0[0].cyc) begin
            e = q0.pop_front();
            total++; bad++;
            $display("FAIL d0_missing_resp exp_cyc=%0d now=%0d", e.cyc, cyc);
        end
        if (m0.resp) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL d0_unexpected_resp cyc=%0d", cyc);
            end else if (q0[0].cyc != cyc) begin
                bad++;
                $display("FAIL d0_resp_timing act=%0d exp=%0d", cyc, q0[0].cyc);
            end else begin
                e = q0.pop_front();
                if (e.chk) chk32("d0_rdata", m0.rdata, e.rd);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0 && cyc > q1[0].cyc) begin
            e = q1.pop_front();
            total++; bad++;
            $display("FAIL d1_missing_resp exp_cyc=%0d now=%0d", e.cyc, cyc);
        end
        if (m1.resp) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL d1_unexpected_resp cyc=%0d", cyc);
            end else if (q1[0].cyc != cyc) begin
                bad++;
                $display("FAIL d1_resp_timing act=%0d exp=%0d", cyc, q1[0].cyc);
            end else begin
                e = q1.pop_front();
                if (e.chk) chk32("d1_rdata", m1.rdata, e.rd);
            end
        end
    end

    task automatic drive(input int w, input logic rd, input logic wr, input logic [3:0] mk,
                         input logic [31:0] a, input logic [31:0] d);
        if (w == 0) begin
            m0.read = rd; m0.write = wr; m0.wmask = mk; m0.address = a; m0.wdata = d;
        end else begin
            m1.read = rd; m1.write = wr; m1.wmask = mk; m1.address = a; m1.wdata = d;
        end
    endtask

    task automatic push(input int w, input logic [31:0] ex, input logic chk, input int c);
        exp_t e;
        e.rd = ex; e.chk = chk; e.cyc = c;
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called at #1 after a rising edge in an IDLE cycle; returns likewise.
    task automatic req(input int w, input logic rd, input logic wr, input logic [3:0] mk,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic chk, input logic [31:0] ex, input bit glitch);
        int lat;
        lat = (w == 0) ? 2 : 1;
        drive(w, rd, wr, mk, a, d);
        push(w, ex, chk, cyc + lat);
        repeat (lat) begin
            @(posedge clk); #1;
            if (glitch) drive(w, 1'b0, 1'b0, ~mk, a ^ 32'h44, ~d);
        end
        drive(w, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    // Read held high; address steps by 4 in each resp cycle.
    task automatic stream(input int w, input logic [31:0] base, input logic [31:0] ex [4]);
        int lat;
        int t;
        lat = (w == 0) ? 2 : 1;
        drive(w, 1'b1, 1'b0, 4'h0, base, 32'h0);
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            push(w, ex[k], 1'b1, t + lat + k * (lat + 1));
            repeat (lat) begin @(posedge clk); #1; end
            if (k < 3) drive(w, 1'b1, 1'b0, 4'h0, base + 32'(4 * (k + 1)), 32'h0);
            else       drive(w, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] s0 [4];
    logic [31:0] s1 [4];

    initial begin
        s0 = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
        s1 = '{32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0BADF00D};
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk32("rst_resp0", {31'h0, m0.resp}, 32'h0);
        chk32("rst_rdata0", m0.rdata, 32'h0);
        chk32("rst_resp1", {31'h0, m1.resp}, 32'h0);
        chk32("rst_rdata1", m1.rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // write then read, full mask, partial mask, empty mask
        req(0, 1'b0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        req(0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        req(0, 1'b0, 1'b1, 4'b0101, 32'h40, 32'h11223344, 1'b1, 32'hDEADBEEF, 1'b0);
        req(0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'hDE22BE44, 1'b0);
        req(0, 1'b0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 1'b1, 32'hDE22BE44, 1'b0);
        req(0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'hDE22BE44, 1'b0);

        // preload and stream with read tied high
        for (int k = 0; k < 4; k++)
            req(0, 1'b0, 1'b1, 4'hF, 32'h100 + 32'(4 * k), s0[k], 1'b0, 32'h0, 1'b0);
        stream(0, 32'h100, s0);

        // aliasing on low and high address bits
        req(0, 1'b0, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 1'b1, 32'hDE22BE44, 1'b0);
        req(0, 1'b1, 1'b0, 4'h0, 32'h43, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
        req(0, 1'b1, 1'b0, 4'h0, 32'h1000_0040, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);

        // read and write together: write wins, rdata is pre-write word
        req(0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
        req(0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'h00000000, 1'b0);

        // inputs scrambled after accept must not affect the latched op
        req(0, 1'b0, 1'b1, 4'hF, 32'h104, 32'h77665544, 1'b1, 32'hA0000002, 1'b1);
        req(0, 1'b1, 1'b0, 4'h0, 32'h104, 32'h0, 1'b1, 32'h77665544, 1'b1);
        req(0, 1'b1, 1'b0, 4'h0, 32'h140, 32'h0, 1'b0, 32'h0, 1'b0);
        req(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 32'hA0000001, 1'b0);

        // reset in WAIT abandons the write
        req(0, 1'b0, 1'b1, 4'hF, 32'h80, 32'h55AA55AA, 1'b0, 32'h0, 1'b0);
        drive(0, 1'b0, 1'b1, 4'hF, 32'h80, 32'h12345678);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk32("midrst_resp", {31'h0, m0.resp}, 32'h0);
        chk32("midrst_rdata", m0.rdata, 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        req(0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 1'b1, 32'h55AA55AA, 1'b0);

        // LATENCY=1 responder
        for (int k = 0; k < 3; k++)
            req(1, 1'b0, 1'b1, 4'hF, 32'(4 * k), s1[k], 1'b0, 32'h0, 1'b0);
        req(1, 1'b0, 1'b1, 4'b1100, 32'hC, 32'h0BAD0000, 1'b0, 32'h0, 1'b0);
        req(1, 1'b0, 1'b1, 4'b0011, 32'hC, 32'h1234F00D, 1'b0, 32'h0, 1'b0);
        stream(1, 32'h0, s1);

        repeat (5) @(posedge clk);
        #1;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL queues_drained act=%0d/%0d exp=0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
